reg_targetio_trigger: RTL
=========================

# reg_targetio_trigger

Parametrised register-bus slave that owns NUM_IO target I/O pins. It controls each pin's drive mode, then synchronises and glitch-filters the inputs. It combines a masked, polarity-adjusted subset into a registered trigger output and counts trigger events. It sits on the shared register bus alongside the other reg_* blocks, with its read data and hyplen OR-combined at the top level, and generalises the fixed four-line IO/trigger handling to N lines with filtering and combine modes.

## Interface
Parameters:
- NUM_IO, 4, number of target I/O pins; legal range 1..8
- FILT_W, 16, filter-threshold and filter-counter width; legal range 1..16
- ADDR_BASE, 6'd50, first of four consecutive register addresses

Ports:
- clk  input  1  register-bus clock, sole clock
- reset_i  input  1  asynchronous, active-high reset
- reg_address  input  6  register address
- reg_bytecnt  input  16  byte index within the register
- reg_datai  input  8  write data from the host
- reg_datao  output  8  read data; 0 when this block is not addressed
- reg_size  input  16  transfer size; unused
- reg_read  input  1  read strobe
- reg_write  input  1  write strobe
- reg_addrvalid  input  1  address-valid qualifier
- reg_hypaddress  input  6  address for the length query
- reg_hyplen  output  16  register length for reg_hypaddress; 0 when not owned
- reg_stream  output  1  tied 0
- target_io  inout  NUM_IO  target pins
- alt_i  input  NUM_IO  alternate drive source per pin, e.g. UART TX
- io_level_o  output  NUM_IO  filtered pin levels
- trigger_o  output  1  combined trigger

## Operation
Registers. Byte k of each register is at reg_bytecnt=k.
- ADDR_BASE+0 IOMODE: NUM_IO bytes. Byte k bits[1:0] set pin k:
  - 00: Z
  - 01: drive 0
  - 10: drive 1
  - 11: drive alt_i[k]
- ADDR_BASE+1 TRIGCFG: 3 bytes.
  - Byte 0: mask.
  - Byte 1: invert.
  - Byte 2 bits[1:0] select the combine: 00 OR, 01 AND, 10 NAND, 11 off.
  - Byte 2 bit2 edge: 0 = level output, 1 = one-cycle pulse on the rising edge of the combine.
- ADDR_BASE+2 FILTER: 2 bytes, little-endian, threshold F (FILT_W bits).
- ADDR_BASE+3 STATUS: 3 bytes.
  - Byte 0: io_level_o.
  - Bytes 1-2: 16-bit event counter, little-endian.
  - A write of any byte clears the counter.

Bus behaviour:
- Write: takes effect when reg_write && reg_addrvalid && the address matches. Only byte reg_bytecnt is updated. Out-of-range bytecnt is ignored. Unused high bits of mask and invert are ignored.
- hyplen (combinational): IOMODE→NUM_IO, TRIGCFG→3, FILTER→2, STATUS→3, otherwise 0.
- Pin drive: combinational from IOMODE; there is no register stage on the output enable.

Input path:
- Sync: 2-FF synchroniser per pin produces s[k].
- Filter, per pin, with counter c and filtered level f:
  - if s==f: c←0
  - else if c>=F: f←s, c←0
  - else: c←c+1
  - c saturates at all-ones.
- Combine: x = f ^ invert.
  - OR = |(x&mask)
  - AND = &(x|~mask)
  - NAND = ~AND
  - Result is forced to 0 whenever mask==0, in every mode.
  - The combine result is registered as t.
- Output: trigger_o = t when edge=0; t & ~t_d when edge=1.
- Counter: increments on each rising edge of t and saturates at 0xFFFF.

## Timing
- Reset: all registers clear.
  - IOMODE=Z, mask=0, invert=0, combine=OR, edge=0, F=0.
  - Counter, s, f, c, t, trigger_o, reg_datao and io_level_o are all 0.
  - Pins go Z immediately on reset assertion, including mid-transfer or mid-filter.
- Read latency: reg_datao is registered and valid 1 cycle after address/bytecnt are presented with reg_addrvalid. Otherwise it is 0 on the next cycle.
- Pin-to-trigger latency: 4+F cycles (2 sync + 1+F filter + 1 combine), level or edge mode.
- A glitch shorter than F+1 cycles is rejected.
- A new F takes effect on the cycle after the write. If c already exceeds the new F, f updates on the next mismatching cycle.
- A counter-clear write and a rising edge on t in the same cycle: clear wins, counter reads 0.
- A TRIGCFG write is seen by the combine on the next cycle.
- An edge-mode switch while t=1 produces no pulse.

## Configuration
- TARGETIO_FILTER_EN defined: filter counters are built as described.
- TARGETIO_FILTER_EN undefined:
  - No counters are built; f←s every cycle and latency is fixed at 4.
  - FILTER reads 0, writes are ignored, hyplen still reports 2.

## Test plan
- Reset then read all registers → every byte is 0; target_io all Z; trigger_o=0.
- IOMODE bytes 01,10,11,00 with alt_i[2]=1 → io0=0, io1=1, io2=1, io3=Z.
- mask=0x03, OR, F=0; raise io1 → trigger_o=1 exactly 4 cycles later; counter reads 1.
- F=5; 5-cycle pulse on io0 → no trigger; 6-cycle pulse → trigger_o rises 9 cycles after the pulse edge.
- mask=0x0F, invert=0x01, AND, edge=1; io=0b1110 → single 1-cycle trigger_o pulse, counter increments by 1.
- Counter at 0xFFFF plus one further edge → stays 0xFFFF; a STATUS write coinciding with an edge → reads 0.

Source files
------------

// File: rtl/reg_targetio_trigger_if.sv
// Shared register-bus bundle for reg_targetio_trigger; slave is the block, master is the host side.
interface reg_targetio_trigger_if;
  logic [5:0]  reg_address;
  logic [15:0] reg_bytecnt;
  logic [7:0]  reg_datai;
  logic [7:0]  reg_datao;
  logic [15:0] reg_size;
  logic        reg_read;
  logic        reg_write;
  logic        reg_addrvalid;
  logic [5:0]  reg_hypaddress;
  logic [15:0] reg_hyplen;
  logic        reg_stream;

  modport slave (
    input  reg_address, reg_bytecnt, reg_datai, reg_size, reg_read, reg_write,
           reg_addrvalid, reg_hypaddress,
    output reg_datao, reg_hyplen, reg_stream
  );

  modport master (
    output reg_address, reg_bytecnt, reg_datai, reg_size, reg_read, reg_write,
           reg_addrvalid, reg_hypaddress,
    input  reg_datao, reg_hyplen, reg_stream
  );
endinterface

// File: rtl/reg_targetio_trigger.sv
// Target I/O pin block: per-pin drive mode, 2-FF sync, glitch filter, masked trigger combine, event counter.
// Optional feature macro TARGETIO_FILTER_EN builds the per-pin filter counters and the FILTER register.
module reg_targetio_trigger #(
  parameter int         NUM_IO    = 4,
  parameter int         FILT_W    = 16,
  parameter logic [5:0] ADDR_BASE = 6'd50
) (
  input  logic                  clk,
  input  logic                  reset_i,
  reg_targetio_trigger_if.slave bus,
  inout  wire  [NUM_IO-1:0]     target_io,
  input  logic [NUM_IO-1:0]     alt_i,
  output logic [NUM_IO-1:0]     io_level_o,
  output logic                  trigger_o
);
  localparam logic [5:0] A_IOMODE = ADDR_BASE;
  localparam logic [5:0] A_TRIG   = ADDR_BASE + 6'd1;
  localparam logic [5:0] A_FILT   = ADDR_BASE + 6'd2;
  localparam logic [5:0] A_STAT   = ADDR_BASE + 6'd3;

  logic [1:0]        r_iomode [NUM_IO];
  logic [NUM_IO-1:0] r_mask, r_invert;
  logic [1:0]        r_comb;
  logic              r_edge;
  logic [15:0]       r_evt_cnt;
  logic [NUM_IO-1:0] r_s1, r_s2, r_f;
  logic              r_t, r_t_d;
  logic [7:0]        r_datao;

  logic              w_wr, w_clr, w_rise, w_comb, w_or, w_and;
  logic [NUM_IO-1:0] w_oe, w_do, w_x;
  logic [15:0]       w_filt_ext, w_hyplen;
  logic [7:0]        w_rdata;
  logic              w_unused;

  assign w_wr     = bus.reg_write && bus.reg_addrvalid;
  assign w_clr    = w_wr && (bus.reg_address == A_STAT) && (bus.reg_bytecnt < 16'd3);
  assign w_rise   = r_t & ~r_t_d;
  assign w_unused = ^{bus.reg_size, bus.reg_read, bus.reg_datai};

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < NUM_IO; k++) r_iomode[k] <= 2'b00;
      r_mask   <= '0;
      r_invert <= '0;
      r_comb   <= 2'b00;
      r_edge   <= 1'b0;
    end else if (w_wr) begin
      if (bus.reg_address == A_IOMODE) begin
        for (int k = 0; k < NUM_IO; k++)
          if (bus.reg_bytecnt == 16'(k)) r_iomode[k] <= bus.reg_datai[1:0];
      end
      if (bus.reg_address == A_TRIG) begin
        case (bus.reg_bytecnt)
          16'd0: r_mask   <= bus.reg_datai[NUM_IO-1:0];
          16'd1: r_invert <= bus.reg_datai[NUM_IO-1:0];
          16'd2: begin
            r_comb <= bus.reg_datai[1:0];
            r_edge <= bus.reg_datai[2];
          end
          default: ;
        endcase
      end
    end
  end

  // Output enable is purely combinational from IOMODE so reset floats the pins immediately.
  always_comb begin
    w_oe = '0;
    w_do = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      w_oe[k] = (r_iomode[k] != 2'b00);
      case (r_iomode[k])
        2'b10:   w_do[k] = 1'b1;
        2'b11:   w_do[k] = alt_i[k];
        default: w_do[k] = 1'b0;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_IO; g++) begin : g_pin
    assign target_io[g] = w_oe[g] ? w_do[g] : 1'bz;
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= target_io;
      r_s2 <= r_s1;
    end
  end

`ifdef TARGETIO_FILTER_EN
  logic [FILT_W-1:0] r_filt;
  logic [FILT_W-1:0] r_c [NUM_IO];
  logic [15:0]       w_filt_nxt;

  assign w_filt_ext = 16'(r_filt);

  always_comb begin
    w_filt_nxt = w_filt_ext;
    if (bus.reg_bytecnt == 16'd0)      w_filt_nxt[7:0]  = bus.reg_datai;
    else if (bus.reg_bytecnt == 16'd1) w_filt_nxt[15:8] = bus.reg_datai;
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_filt <= '0;
    end else if (w_wr && (bus.reg_address == A_FILT) && (bus.reg_bytecnt < 16'd2)) begin
      r_filt <= w_filt_nxt[FILT_W-1:0];
    end
  end

  // A level must persist for F+1 consecutive mismatching samples before f follows it.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_f <= '0;
      for (int k = 0; k < NUM_IO; k++) r_c[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_IO; k++) begin
        if (r_s2[k] == r_f[k]) begin
          r_c[k] <= '0;
        end else if (r_c[k] >= r_filt) begin
          r_f[k] <= r_s2[k];
          r_c[k] <= '0;
        end else if (r_c[k] != '1) begin
          r_c[k] <= r_c[k] + 1'b1;
        end
      end
    end
  end
`else
  assign w_filt_ext = 16'h0000;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) r_f <= '0;
    else         r_f <= r_s2;
  end
`endif

  assign io_level_o = r_f;

  always_comb begin
    w_x    = r_f ^ r_invert;
    w_or   = |(w_x & r_mask);
    w_and  = &(w_x | ~r_mask);
    w_comb = 1'b0;
    case (r_comb)
      2'b00:   w_comb = w_or;
      2'b01:   w_comb = w_and;
      2'b10:   w_comb = ~w_and;
      default: w_comb = 1'b0;
    endcase
    if (r_mask == '0) w_comb = 1'b0;
  end

  // Counter clear takes priority over a coincident rising edge of t.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_t       <= 1'b0;
      r_t_d     <= 1'b0;
      r_evt_cnt <= 16'h0000;
    end else begin
      r_t   <= w_comb;
      r_t_d <= r_t;
      if (w_clr) r_evt_cnt <= 16'h0000;
      else if (w_rise && (r_evt_cnt != 16'hFFFF)) r_evt_cnt <= r_evt_cnt + 16'd1;
    end
  end

  assign trigger_o = r_edge ? w_rise : r_t;

  always_comb begin
    w_rdata = 8'h00;
    if (bus.reg_address == A_IOMODE) begin
      for (int k = 0; k < NUM_IO; k++)
        if (bus.reg_bytecnt == 16'(k)) w_rdata = {6'b000000, r_iomode[k]};
    end else if (bus.reg_address == A_TRIG) begin
      case (bus.reg_bytecnt)
        16'd0:   w_rdata = 8'(r_mask);
        16'd1:   w_rdata = 8'(r_invert);
        16'd2:   w_rdata = {5'b00000, r_edge, r_comb};
        default: w_rdata = 8'h00;
      endcase
    end else if (bus.reg_address == A_FILT) begin
      case (bus.reg_bytecnt)
        16'd0:   w_rdata = w_filt_ext[7:0];
        16'd1:   w_rdata = w_filt_ext[15:8];
        default: w_rdata = 8'h00;
      endcase
    end else if (bus.reg_address == A_STAT) begin
      case (bus.reg_bytecnt)
        16'd0:   w_rdata = 8'(r_f);
        16'd1:   w_rdata = r_evt_cnt[7:0];
        16'd2:   w_rdata = r_evt_cnt[15:8];
        default: w_rdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) r_datao <= 8'h00;
    else         r_datao <= bus.reg_addrvalid ? w_rdata : 8'h00;
  end

  always_comb begin
    w_hyplen = 16'h0000;
    case (bus.reg_hypaddress)
      A_IOMODE: w_hyplen = 16'(NUM_IO);
      A_TRIG:   w_hyplen = 16'd3;
      A_FILT:   w_hyplen = 16'd2;
      A_STAT:   w_hyplen = 16'd3;
      default:  w_hyplen = 16'h0000;
    endcase
  end

  assign bus.reg_datao  = r_datao;
  assign bus.reg_hyplen = w_hyplen;
  assign bus.reg_stream = 1'b0;
endmodule
